// File: rtl/input_read_sequencer.sv
// Read-address sequencer for one PE-array tile: walks a rows x cols window of the
// input buffer, issues one read per unpaused cycle, then waits for every beat to return.
module input_read_sequencer #(
  parameter int ADDR_W = 11,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] row_stride,
  input  logic [CNT_W-1:0]  tile_rows,
  input  logic [CNT_W-1:0]  tile_cols,
  input  logic              pause,
  input  logic              data_valid_in,
  output logic [ADDR_W-1:0] addr_read_input,
  output logic              read_en_input,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic [1:0]        state_dbg
);
  // Handshake: read_en_input=1 means addr_read_input is a read request this cycle
  // (no ready; the master always accepts). Each request returns exactly one
  // data_valid_in beat some cycles later; beats are counted, never matched.

  localparam int CW = 2 * CNT_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cols;
  logic [CNT_W-1:0]  col;
  logic [ADDR_W-1:0] stride;
  logic [ADDR_W-1:0] row_base;
  logic [CW-1:0]     issued;
  logic [CW-1:0]     returned;
  logic [CW-1:0]     total;
  logic              beat;
  logic [CW-1:0]     returned_nxt;
  logic              zero_dim;

  always_comb begin
    beat         = data_valid_in && ((state == S_ISSUE) || (state == S_DRAIN));
    returned_nxt = returned + CW'(beat);
    zero_dim     = (tile_rows == '0) || (tile_cols == '0);
  end

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      cols            <= '0;
      col             <= '0;
      stride          <= '0;
      row_base        <= '0;
      issued          <= '0;
      returned        <= '0;
      total           <= '0;
      addr_read_input <= '0;
      read_en_input   <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      cfg_err         <= 1'b0;
    end else begin
      done          <= 1'b0;
      read_en_input <= 1'b0;
      returned      <= returned_nxt;
      case (state)
        S_IDLE: begin
          busy <= 1'b0;
          // done is still high on the first IDLE cycle: a start there is dropped
          if (start && !done) begin
            cols     <= tile_cols;
            col      <= '0;
            stride   <= row_stride;
            row_base <= base_addr;
            issued   <= '0;
            returned <= '0;
            total    <= CW'(tile_rows) * CW'(tile_cols);
            cfg_err  <= zero_dim;
            busy     <= 1'b1;
            state    <= zero_dim ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!pause) begin
            read_en_input   <= 1'b1;
            addr_read_input <= row_base + ADDR_W'(col);
            issued          <= issued + CW'(1);
            if (col == cols - CNT_W'(1)) begin
              col      <= '0;
              row_base <= row_base + stride;
            end else begin
              col <= col + CNT_W'(1);
            end
            if (issued + CW'(1) == total) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (returned_nxt >= total) state <= S_DONE;
        end
        default: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_input_read_sequencer.sv
// Directed bench: driver tasks queue expected addresses / done outcomes; a negedge
// monitor pops and compares whenever the DUT presents a read or a done pulse.
module tb_input_read_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [10:0] base_addr;
  logic [10:0] row_stride;
  logic [5:0]  tile_rows;
  logic [5:0]  tile_cols;
  logic        pause;
  logic        data_valid_in;
  logic [10:0] addr_read_input;
  logic        read_en_input;
  logic        busy;
  logic        done;
  logic        cfg_err;
  logic [1:0]  state_dbg;

  input_read_sequencer #(.ADDR_W(11), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .row_stride(row_stride), .tile_rows(tile_rows), .tile_cols(tile_cols),
    .pause(pause), .data_valid_in(data_valid_in),
    .addr_read_input(addr_read_input), .read_en_input(read_en_input),
    .busy(busy), .done(done), .cfg_err(cfg_err), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // read master model: one beat back per request, fixed delay
  logic [1:0] rd_pipe = 2'b00;
  initial data_valid_in = 1'b0;
  always begin
    @(posedge clk);
    #1;
    data_valid_in = rd_pipe[1];
    rd_pipe = {rd_pipe[0], read_en_input};
  end

  // scoreboard
  int total_cnt = 0;
  int bad_cnt = 0;
  logic [10:0] exp_q[$];
  logic        exp_err_q[$];
  int done_cnt = 0, done_cyc = 0, read_cnt = 0, first_rd = 0, last_rd = 0;
  bit done_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act !== req) begin
      bad_cnt++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      done_prev = 1'b0;
    end else begin
      if (done_prev) check("busy_after_done", busy, 0);
      done_prev = done;
      if (read_en_input) begin
        read_cnt++;
        if (read_cnt == 1) first_rd = cyc;
        last_rd = cyc;
        if (exp_q.size() == 0) begin
          total_cnt++; bad_cnt++;
          $display("FAIL unexpected_read: got addr %0h want no read", addr_read_input);
        end else begin
          check("read_addr", addr_read_input, exp_q.pop_front());
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("busy_on_done", busy, 1);
        if (exp_err_q.size() == 0) begin
          total_cnt++; bad_cnt++;
          $display("FAIL unexpected_done: got done=1 want 0");
        end else begin
          check("cfg_err_on_done", cfg_err, exp_err_q.pop_front());
        end
      end
    end
  end

  // driver
  task automatic run_tile(input logic [10:0] b, input logic [10:0] s, input logic [5:0] r,
                          input logic [5:0] c, input logic [15:0] pmask, input int restart_at,
                          input bit start_on_done, input int exp_span);
    int t0, dc0;
    bit exp_err;
    exp_err = (r == 0) || (c == 0);
    if (!exp_err)
      for (int rr = 0; rr < r; rr++)
        for (int cc = 0; cc < c; cc++)
          exp_q.push_back(11'(b + rr * s + cc));
    exp_err_q.push_back(exp_err);
    dc0 = done_cnt;
    read_cnt = 0;
    @(posedge clk); #1;
    base_addr = b; row_stride = s; tile_rows = r; tile_cols = c; start = 1'b1;
    t0 = cyc;
    for (int i = 1; i < 300 && done_cnt == dc0; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      pause = (i < 16) ? pmask[i] : 1'b0;
      if (i == restart_at || (start_on_done && done)) begin
        start = 1'b1; base_addr = 11'h155; row_stride = 11'd3; tile_rows = 6'd2; tile_cols = 6'd2;
      end
    end
    start = 1'b0; pause = 1'b0;
    if (done_cnt == dc0) begin
      total_cnt++; bad_cnt++;
      $display("FAIL done_timeout: got no done within 300 cycles want done");
      exp_q.delete(); exp_err_q.delete();
    end
    repeat (4) @(posedge clk);
    #1;
    check("all_reads_seen", exp_q.size(), 0);
    check("idle_busy", busy, 0);
    check("idle_state", state_dbg, 0);
    if (exp_span >= 0) check("read_span", last_rd - first_rd, exp_span);
    if (exp_err) begin
      check("err_reads", read_cnt, 0);
      check("err_done_latency", done_cyc - t0, 2);
      check("cfg_err_sticky", cfg_err, 1);
    end else begin
      check("read_count", read_cnt, r * c);
      check("cfg_err_clear", cfg_err, 0);
    end
  endtask

  task automatic reset_mid_issue();
    int dc0;
    for (int i = 0; i < 6; i++) exp_q.push_back(11'h010 + 11'(i / 3) * 11'd8 + 11'(i % 3));
    read_cnt = 0;
    dc0 = done_cnt;
    @(posedge clk); #1;
    base_addr = 11'h010; row_stride = 11'd8; tile_rows = 6'd2; tile_cols = 6'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 50 && read_cnt < 3; i++) begin
      @(negedge clk); #1;
    end
    check("reads_before_reset", read_cnt, 3);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rst_read_en", read_en_input, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("no_done_after_reset", done_cnt, dc0);
    check("rst_idle_busy", busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; pause = 1'b0;
    base_addr = '0; row_stride = '0; tile_rows = '0; tile_cols = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_addr", addr_read_input, 0);
    check("reset_read_en", read_en_input, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_cfg_err", cfg_err, 0);
    check("reset_state", state_dbg, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_tile(11'h010, 11'd8, 6'd2, 6'd3, 16'h0000, -1, 1'b0, 5);   // T1 plain
    run_tile(11'h010, 11'd8, 6'd2, 6'd3, 16'h000C, -1, 1'b0, 7);   // T2 two paused cycles
    run_tile(11'h010, 11'd8, 6'd2, 6'd0, 16'h0000, -1, 1'b0, -1);  // T3 zero cols
    run_tile(11'h7FE, 11'd1, 6'd1, 6'd4, 16'h0000, -1, 1'b0, 3);   // T4 address wrap
    reset_mid_issue();                                             // T5
    run_tile(11'h010, 11'd8, 6'd2, 6'd3, 16'h0000, -1, 1'b0, 5);
    run_tile(11'h010, 11'd8, 6'd2, 6'd3, 16'h0000, 3, 1'b1, 5);    // T6 stray starts
    run_tile(11'h020, 11'd16, 6'd3, 6'd2, 16'h0052, -1, 1'b0, -1); // scattered pauses

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end
endmodule
